alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 4: operand and result width in bits.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  Requester 0/1 presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  Operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  N each  Operands per requester.
REQ-007 req0_op / req1_op  input  2 each  alu_control code per requester.
REQ-008 lu_a, lu_b  output  N each  Operands driven to the shared LogicUnit.
REQ-009 lu_ctrl  output  2  alu_control driven to the shared LogicUnit.
REQ-010 lu_result  input  N  Combinational result returned by the LogicUnit.
REQ-011 resp_valid  output  1  Response holding.
REQ-012 resp_ready  input  1  Consumer takes the response.
REQ-013 resp_data  output  N  Captured LogicUnit result.
REQ-014 resp_id  output  1  Requester index owning resp_data.

Function
REQ-015 States: IDLE, EXEC, RESP; FSM in exactly one state at all times.
REQ-016 IDLE: no valid request -> remain IDLE, both readies low.
REQ-017 IDLE: one or more valid -> grant per REQ-021, assert granting reqX_ready for exactly that cycle, latch its a/b/op and index, go EXEC.
REQ-018 readies combinational: asserted only in IDLE, only to granted requester, never both.
REQ-019 EXEC (one cycle): lu_a/lu_b/lu_ctrl = latched operands; at cycle end capture lu_result into resp_data, latched index into resp_id, go RESP.
REQ-020 RESP: resp_valid high, resp_data/resp_id stable; on resp_valid && resp_ready -> IDLE, resp_valid low next cycle; else stay RESP.
REQ-021 Round-robin: 1-bit priority pointer, reset value 0; only one valid -> it wins; both valid -> pointer owner wins; pointer set to loser of each grant.
REQ-022 Latency: accept at edge t, resp_valid high from t+2; throughput max one op per 3 cycles when resp_ready held high.
REQ-023 Requests asserted outside IDLE ignored (no ready); requesters hold valid and operands until ready.
REQ-024 lu_a/lu_b/lu_ctrl hold latched operand registers in all states (glitch-free, no requester muxing).
REQ-025 Results N bits, no width extension or truncation; resp_data equals lu_result exactly as sampled in EXEC.
REQ-026 Operand change on a requester after acceptance has no effect on the op in flight.

Reset
REQ-027 rst_n low asynchronously forces IDLE, pointer 0, operand/op registers 0, resp_data 0, resp_id 0.
REQ-028 During reset and first cycle after: resp_valid, req0_ready, req1_ready all 0; lu_a, lu_b, lu_ctrl all 0.
REQ-029 Reset mid-EXEC or mid-RESP drops the in-flight op; no response issued for it after release.

Verification
REQ-030 Single req: req0 a=2,b=1,op=0 valid, resp_ready=1 -> req0_ready one cycle; resp_valid two edges later, resp_id=0, resp_data = LogicUnit(2,1,op0).
REQ-031 Contention: both valid from reset, req0 op=1, req1 op=2 -> grant order req0, req1, req0...; resp_id sequence 0,1,0 with matching results.
REQ-032 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_data, resp_id stable, no readies; release -> exactly one handshake, return to IDLE.
REQ-033 Sweep: ops 0..3 with a=2,b=1 on req1 only -> four responses resp_id=1, data matching each op, pointer irrelevant.
REQ-034 Reset mid-op: rst_n low during EXEC -> all outputs 0 immediately; after release no stale response; next request served normally with pointer 0.
REQ-035 Operand hold: change req0_a after req0_ready -> response reflects originally accepted value.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of signals between two requesters, the arbiter, the shared LogicUnit
// and the response consumer. The arbiter takes the slave view.
`timescale 1ns/1ps
interface alu_arbiter_if #(
  parameter int N = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [1:0]   req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic [1:0]   req1_op;

  logic [N-1:0] lu_a;
  logic [N-1:0] lu_b;
  logic [1:0]   lu_ctrl;
  logic [N-1:0] lu_result;

  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_data;
  logic         resp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  lu_a, lu_b, lu_ctrl,
    output lu_result,
    input  resp_valid, resp_data, resp_id,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output lu_a, lu_b, lu_ctrl,
    input  lu_result,
    output resp_valid, resp_data, resp_id,
    input  resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational LogicUnit between two requesters.
// state | meaning
// IDLE  | waiting for a request; grants one and latches its operands
// EXEC  | latched operands on the LogicUnit; result captured at cycle end
// RESP  | response held until the consumer takes it
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int N = 4
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state;
  logic         ptr;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [1:0]   op_q;
  logic         id_q;
  logic [N-1:0] data_q;
  logic         rid_q;
  logic         rvalid_q;

  logic in_idle;
  logic any_req;
  logic grant1;

  assign in_idle = (state == IDLE);
  assign any_req = bus.req0_valid | bus.req1_valid;
  // req1 wins when it is alone or when the pointer favours it
  assign grant1  = bus.req1_valid & (~bus.req0_valid | ptr);

  assign bus.req0_ready = in_idle & bus.req0_valid & ~grant1;
  assign bus.req1_ready = in_idle & grant1;

  assign bus.lu_a       = a_q;
  assign bus.lu_b       = b_q;
  assign bus.lu_ctrl    = op_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = rid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      data_q   <= '0;
      rid_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            a_q   <= grant1 ? bus.req1_a  : bus.req0_a;
            b_q   <= grant1 ? bus.req1_b  : bus.req0_b;
            op_q  <= grant1 ? bus.req1_op : bus.req0_op;
            id_q  <= grant1;
            ptr   <= ~grant1;
            state <= EXEC;
          end
        end
        EXEC: begin
          data_q   <= bus.lu_result;
          rid_q    <= id_q;
          rvalid_q <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the LogicUnit is modelled here as
// op0 AND, op1 OR, op2 XOR, op3 NOR.
`timescale 1ns/1ps
module tb_alu_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_arbiter_if #(.N(4)) bus ();

  alu_arbiter #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [3:0] lu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  assign bus.lu_result = lu(bus.lu_a, bus.lu_b, bus.lu_ctrl);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic wait_grant(output logic ok, output logic id, output logic both);
    ok = 1'b0; id = 1'b0; both = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        ok = 1'b1; id = bus.req1_ready; both = bus.req0_ready & bus.req1_ready;
        break;
      end
    end
  endtask

  task automatic wait_resp(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.resp_valid, bus.req0_ready, bus.req1_ready, bus.lu_a, bus.lu_b, bus.lu_ctrl, bus.resp_data, bus.resp_id} !== '0) begin
      bad++;
      $display("FAIL reset_during: rv=%b r0=%b r1=%b lu_a=%h lu_b=%h ctrl=%h data=%h id=%b want all 0",
               bus.resp_valid, bus.req0_ready, bus.req1_ready, bus.lu_a, bus.lu_b, bus.lu_ctrl, bus.resp_data, bus.resp_id);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.resp_valid, bus.req0_ready, bus.req1_ready, bus.lu_a, bus.lu_b, bus.lu_ctrl} !== '0) begin
      bad++;
      $display("FAIL reset_after: rv=%b r0=%b r1=%b lu_a=%h lu_b=%h ctrl=%h want all 0",
               bus.resp_valid, bus.req0_ready, bus.req1_ready, bus.lu_a, bus.lu_b, bus.lu_ctrl);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd1; bus.req0_op = 2'd0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp_valid} !== 3'b100) begin
      bad++; $display("FAIL single_grant: r0,r1,rv=%b want 100", {bus.req0_ready, bus.req1_ready, bus.resp_valid});
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.resp_valid, bus.req0_ready, bus.lu_a, bus.lu_b, bus.lu_ctrl} !== {1'b0, 1'b0, 4'd2, 4'd1, 2'd0}) begin
      bad++; $display("FAIL single_exec: rv=%b r0=%b lu_a=%h lu_b=%h ctrl=%h want 0 0 2 1 0",
                      bus.resp_valid, bus.req0_ready, bus.lu_a, bus.lu_b, bus.lu_ctrl);
    end
    @(negedge clk);
    total++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {1'b1, 1'b0, 4'h0}) begin
      bad++; $display("FAIL single_resp: rv=%b id=%b data=%h want 1 0 0", bus.resp_valid, bus.resp_id, bus.resp_data);
    end
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL single_done: rv=%b want 0", bus.resp_valid);
    end
  endtask

  task automatic test_contention();
    logic ok, id, both;
    logic [3:0] exp_data;
    do_reset();
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd3; bus.req0_op = 2'd1;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd6; bus.req1_b = 4'd3; bus.req1_op = 2'd2;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(ok, id, both);
      total++;
      if (!ok || both || id !== k[0]) begin
        bad++; $display("FAIL contention_grant%0d: ok=%b both=%b id=%b want ok=1 both=0 id=%b", k, ok, both, id, k[0]);
      end
      exp_data = k[0] ? 4'h5 : 4'h7;
      wait_resp(ok);
      total++;
      if (!ok || bus.resp_id !== k[0] || bus.resp_data !== exp_data) begin
        bad++; $display("FAIL contention_resp%0d: ok=%b id=%b data=%h want id=%b data=%h",
                        k, ok, bus.resp_id, bus.resp_data, k[0], exp_data);
      end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic ok, id, both;
    do_reset();
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd9; bus.req0_b = 4'd12; bus.req0_op = 2'd1;
    wait_grant(ok, id, both);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd1; bus.req1_b = 4'd1; bus.req1_op = 2'd0;
    wait_resp(ok);
    total++;
    if (!ok || bus.resp_data !== 4'hD || bus.resp_id !== 1'b0) begin
      bad++; $display("FAIL bp_first: ok=%b data=%h id=%b want data=d id=0", ok, bus.resp_data, bus.resp_id);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bus.resp_valid, bus.resp_data, bus.resp_id, bus.req0_ready, bus.req1_ready} !== {1'b1, 4'hD, 1'b0, 2'b00}) begin
        bad++; $display("FAIL bp_hold%0d: rv=%b data=%h id=%b r0=%b r1=%b want 1 d 0 0 0",
                        i, bus.resp_valid, bus.resp_data, bus.resp_id, bus.req0_ready, bus.req1_ready);
      end
    end
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.resp_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
      bad++; $display("FAIL bp_release: rv=%b r0=%b r1=%b want 000", bus.resp_valid, bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_idle: rv=%b want 0", bus.resp_valid);
    end
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_sweep();
    logic ok, id, both;
    logic [3:0] exp_sweep [4];
    exp_sweep = '{4'h0, 4'h3, 4'h3, 4'hC};
    do_reset();
    bus.resp_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      @(posedge clk); #1;
      bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd1; bus.req1_op = op[1:0];
      wait_grant(ok, id, both);
      total++;
      if (!ok || id !== 1'b1 || both) begin
        bad++; $display("FAIL sweep_grant%0d: ok=%b id=%b both=%b want id=1", op, ok, id, both);
      end
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      wait_resp(ok);
      total++;
      if (!ok || bus.resp_id !== 1'b1 || bus.resp_data !== exp_sweep[op]) begin
        bad++; $display("FAIL sweep_resp%0d: ok=%b id=%b data=%h want id=1 data=%h",
                        op, ok, bus.resp_id, bus.resp_data, exp_sweep[op]);
      end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic ok, id, both;
    do_reset();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd5; bus.req0_op = 2'd2;
    wait_grant(ok, id, both);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    total++;
    if (bus.lu_a !== 4'd3) begin
      bad++; $display("FAIL rmid_exec: lu_a=%h want 3", bus.lu_a);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.lu_a, bus.lu_b, bus.lu_ctrl, bus.resp_valid, bus.resp_data, bus.resp_id, bus.req0_ready, bus.req1_ready} !== '0) begin
      bad++; $display("FAIL rmid_async: lu_a=%h lu_b=%h ctrl=%h rv=%b data=%h id=%b want all 0",
                      bus.lu_a, bus.lu_b, bus.lu_ctrl, bus.resp_valid, bus.resp_data, bus.resp_id);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.resp_valid !== 1'b0) begin
        bad++; $display("FAIL rmid_stale%0d: rv=%b want 0", i, bus.resp_valid);
      end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd5; bus.req0_op = 2'd2;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd1; bus.req1_b = 4'd2; bus.req1_op = 2'd1;
    wait_grant(ok, id, both);
    total++;
    if (!ok || id !== 1'b0 || both) begin
      bad++; $display("FAIL rmid_ptr: ok=%b id=%b both=%b want id=0", ok, id, both);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_resp(ok);
    total++;
    if (!ok || bus.resp_id !== 1'b0 || bus.resp_data !== 4'h6) begin
      bad++; $display("FAIL rmid_resp: ok=%b id=%b data=%h want id=0 data=6", ok, bus.resp_id, bus.resp_data);
    end
  endtask

  task automatic test_operand_hold();
    logic ok, id, both;
    do_reset();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd10; bus.req0_b = 4'd6; bus.req0_op = 2'd2;
    wait_grant(ok, id, both);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req0_a = 4'd1; bus.req0_op = 2'd0;
    @(negedge clk);
    total++;
    if (bus.lu_a !== 4'd10 || bus.lu_ctrl !== 2'd2) begin
      bad++; $display("FAIL hold_lu: lu_a=%h ctrl=%h want a 2", bus.lu_a, bus.lu_ctrl);
    end
    wait_resp(ok);
    total++;
    if (!ok || bus.resp_data !== 4'hC || bus.resp_id !== 1'b0) begin
      bad++; $display("FAIL hold_resp: ok=%b data=%h id=%b want data=c id=0", ok, bus.resp_data, bus.resp_id);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_sweep();
    test_reset_mid();
    test_operand_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
